// File: rtl/minesweeper_status_display.sv
// minesweeper_status_display: tracks game phase, BCD timer and mine count, and registers the 4-digit display word.
module minesweeper_status_display #(
  parameter int TICK_DIV = 100_000_000,
  parameter int MINES    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        first_click,
  input  logic        flag_set,
  input  logic        flag_clr,
  input  logic        game_won,
  input  logic        game_lost,
  input  logic        view_sel,
  output logic [15:0] nums,
  output logic        running
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, WON, LOST} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_pre;
  logic [3:0] r_t2, r_t1, r_t0;
  logic signed [7:0] r_mines;
  logic r_blink, r_running;
  logic [15:0] r_nums;
  logic w_tick, w_half, w_end, w_sat, w_t0w, w_t1w, w_run, w_clr;
  logic [7:0] w_mag;
  logic [3:0] w_tens, w_ones;
  logic [11:0] w_tview;
  logic [15:0] w_mview, w_fmt;
  assign w_run   = r_state == RUN;
  assign w_clr   = !rst || new_game;
  assign w_tick  = r_pre == PW'(TICK_DIV - 1);
  assign w_half  = w_tick || r_pre == PW'(TICK_DIV / 2 - 1);
  assign w_end   = game_won || game_lost;
  assign w_sat   = {r_t2, r_t1, r_t0} == 12'h999;
  assign w_t0w   = r_t0 == 4'd9;
  assign w_t1w   = r_t1 == 4'd9;
  always_comb begin
    w_next = new_game ? IDLE :
             r_state == IDLE && first_click ? RUN :
             w_run && game_lost ? LOST :
             w_run && game_won ? WON : r_state;
  end
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // a tick coinciding with the end of the game is dropped so the timer freezes
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_t2 <= 4'd0;
      r_t1 <= 4'd0;
      r_t0 <= 4'd0;
    end else if (w_run && w_tick && !w_end && !w_sat) begin
      r_t0 <= w_t0w ? 4'd0 : r_t0 + 4'd1;
      if (w_t0w) r_t1 <= w_t1w ? 4'd0 : r_t1 + 4'd1;
      if (w_t0w && w_t1w) r_t2 <= r_t2 + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_pre   <= '0;
      r_blink <= 1'b1;
    end else begin
      r_pre   <= (w_run || r_state == WON) && !w_tick ? r_pre + PW'(1) : '0;
      r_blink <= r_state != WON || (r_blink ^ w_half);
    end
  end
  always_ff @(posedge clk) begin
    if (w_clr) r_mines <= 8'(MINES);
    else if (w_run && flag_set && !flag_clr && r_mines != -8'sd9) r_mines <= r_mines - 8'sd1;
    else if (w_run && flag_clr && !flag_set && r_mines != 8'(MINES)) r_mines <= r_mines + 8'sd1;
  end
  assign w_mag   = r_mines[7] ? 8'(-r_mines) : 8'(r_mines);
  assign w_tens  = 4'(w_mag / 8'd10);
  assign w_ones  = 4'(w_mag % 8'd10);
  assign w_mview = r_mines[7] ? {8'hBB, 4'hA, w_mag[3:0]} :
                   {8'hBB, w_tens == 4'd0 ? 4'hB : w_tens, w_ones};
  assign w_tview = {r_t2 == 4'd0 ? 4'hB : r_t2,
                    r_t2 == 4'd0 && r_t1 == 4'd0 ? 4'hB : r_t1, r_t0};
  always_comb begin
    w_fmt = r_state == IDLE ? (view_sel ? w_mview : 16'hAAAA) :
            r_state == RUN  ? (view_sel ? w_mview : {4'hB, w_tview}) :
            r_state == WON  ? (r_blink ? {4'hE, w_tview} : 16'hBBBB) :
            {4'hD, w_tview};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_nums    <= 16'hAAAA;
      r_running <= 1'b0;
    end else begin
      r_nums    <= w_fmt;
      r_running <= w_run;
    end
  end
  assign nums    = r_nums;
  assign running = r_running;
endmodule
